// File: rtl/mips_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_pkg : constants and types shared across the MIPS pipeline stages
// Rev 1.0
// ----------------------------------------------------------------------------
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam int PC_W    = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_skid_buf : 2-entry FIFO; head register doubles as the stage output
// Rev 1.0
// ----------------------------------------------------------------------------
import mips_pkg::*;

module fetch_skid_buf #(
  parameter int WIDTH = FETCH_ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [1:0]       o_count,
  output logic             o_head_valid,
  output logic [WIDTH-1:0] o_head_data
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_count;
  logic             w_pop;

  assign w_pop        = i_pop && (r_count != 2'd0);
  assign o_count      = r_count;
  assign o_head_valid = (r_count != 2'd0);
  assign o_head_data  = r_head;

  // Flush only clears the count so the head keeps its last contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else if (w_pop && i_push) begin
      if (r_count == 2'd2) begin
        r_head <= r_tail;
        r_tail <= i_push_data;
      end else begin
        r_head <= i_push_data;
      end
    end else if (w_pop) begin
      if (r_count == 2'd2) begin
        r_head <= r_tail;
      end
      r_count <= r_count - 2'd1;
    end else if (i_push) begin
      if (r_count == 2'd0) begin
        r_head <= i_push_data;
      end else begin
        r_tail <= i_push_data;
      end
      if (r_count != 2'd2) begin
        r_count <= r_count + 2'd1;
      end
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(i_push && !w_pop && !i_flush && (r_count == 2'd2)))
    else $error("fetch_skid_buf: push into a full buffer");
`endif

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// if_fetch_stage : PC, imem request credit logic and skid-buffered IF output
// Rev 1.0
// ----------------------------------------------------------------------------
import mips_pkg::*;

module if_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic [DATA_W-1:0] i_imem_rdata,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus4
);

  localparam int ENTRY_W = DATA_W + 2 * ADDR_W;

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_tag;
  logic               r_inflight;

  logic [1:0]         w_count;
  logic               w_head_valid;
  logic               w_pop;
  logic               w_issue;
  logic               w_push;
  logic [2:0]         w_occ;
  logic [ENTRY_W-1:0] w_push_data;
  logic [ENTRY_W-1:0] w_head_data;
  logic               w_unused_ok;

  assign w_unused_ok = &{1'b0, i_redirect_pc[1:0]};

  // Buffered words plus the one in flight must fit in the two entries.
  assign w_pop   = w_head_valid & ~i_stall & ~i_redirect;
  assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = rst & ~i_redirect & (w_occ <= 3'd1);

  assign o_imem_req  = w_issue;
  assign o_imem_addr = r_pc;

  assign w_push      = r_inflight & ~i_redirect;
  assign w_push_data = {i_imem_rdata, r_tag, r_tag + ADDR_W'(PC_STEP)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_tag      <= '0;
      r_inflight <= 1'b0;
    end else if (i_redirect) begin
      r_pc       <= {i_redirect_pc[ADDR_W-1:2], 2'b00};
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_pc       <= r_pc + ADDR_W'(PC_STEP);
      r_tag      <= r_pc;
      r_inflight <= 1'b1;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  fetch_skid_buf #(
    .WIDTH (ENTRY_W)
  ) u_skid (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_data  (w_push_data),
    .i_pop        (w_pop),
    .i_flush      (i_redirect),
    .o_count      (w_count),
    .o_head_valid (w_head_valid),
    .o_head_data  (w_head_data)
  );

  assign o_valid = w_head_valid;
  assign {o_instr, o_pc, o_pc_plus4} = w_head_data;

endmodule
`default_nettype wire
